uart_rx_wb: RTL and testbench
=============================

# uart_rx_wb

UART receiver with a receive FIFO and a 16-bit Wishbone slave register interface. It is the receive half matching the transmit-only `uart_wb`, and it gives the SoC a CPU-readable serial input path. It sits on a Wishbone slave port of `wb_intercon` next to `uart_wb`. It drives a level interrupt into `mpic_wb`.

## Interface
Parameters:
- `DIVISOR`, default 18: clk_i cycles per oversample tick; 16 ticks = 1 bit time. 18 gives ≈115200 baud at 33 MHz.
- `FIFO_AW`, default 4: log2 of the FIFO depth (16 entries).

Ports:
- `clk_i`  in  1  single clock. All logic is on its rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `wb_dat_i`  in  16  write data.
- `wb_dat_o`  out  16  read data, registered.
- `wb_adr_i`  in  32  only bit 1 is decoded: 0 = DATA, 1 = STATUS.
- `wb_sel_i`  in  2  accepted and ignored.
- `wb_we_i`  in  1  write strobe.
- `wb_cyc_i`, `wb_stb_i`  in  1  cycle and strobe.
- `wb_ack_o`  out  1  single-cycle acknowledge.
- `rx_i`  in  1  asynchronous serial input, idle high.
- `irq_o`  out  1  level interrupt, high while the FIFO is not empty.

## Operation
- **Input synchronizer:** two flops, both reset to 1. All RX logic uses the second flop (`rxs`).
- **Tick generator:** divider counts 0..DIVISOR-1 and emits one tick on wrap. The divider and the 4-bit tick counter are cleared when a start edge is detected.
- **RX FSM states:**
  - IDLE: on `rxs`=0, go to START.
  - START: at tick 8, if `rxs`=0 go to DATA; if 1 it was a glitch, go back to IDLE.
  - DATA: sample every 16 ticks, LSB first, into a shift register. After bit 7, go to STOP.
  - STOP: sample after 16 ticks.
    - If `rxs`=1, push the byte and go to IDLE.
    - If `rxs`=0, set `frame_err`, discard the byte, and go to BRK.
  - BRK: wait for `rxs`=1, then go to IDLE.
- **Push when full:** the byte is dropped and sticky `overrun` is set. "Full" is evaluated before any same-cycle pop.
- **DATA read:** returns {7'b0, valid, byte}. `valid` = FIFO not empty. A read of a non-empty FIFO pops one entry. A read of an empty FIFO returns 16'h0000 and does not pop.
- **STATUS read:** returns {12'b0, frame_err, overrun, full, !empty}.
- **STATUS write:** a 1 in bit 2 clears `overrun`; a 1 in bit 3 clears `frame_err` (write-1-to-clear).
- **DATA write:** acknowledged, no effect.
- **Push and pop in the same cycle:** count is unchanged and data order is preserved.
- **Reset** (takes effect mid-frame, mid-cycle and at any other time):
  - FIFO emptied, FSM to IDLE, sticky bits cleared.
  - `wb_ack_o`=0, `wb_dat_o`=0, `irq_o`=0.

## Timing
- **Ack:** `wb_ack_o` <= `wb_cyc_i & wb_stb_i & !wb_ack_o`.
  - Ack comes 1 cycle after the strobe and lasts 1 cycle.
  - Back-to-back strobes are acknowledged every second cycle.
  - `wb_dat_o` is valid in the ack cycle. The pop, and any W1C, takes effect on the same edge that raises ack.
- **Sample points**, measured from the cycle IDLE sees `rxs`=0 (t0), with `rxs` lagging `rx_i` by 2 cycles:
  - start verify at 8·DIVISOR;
  - data bit n at (24+16n)·DIVISOR;
  - stop bit at 152·DIVISOR.
- **Push latency:** the byte is written on the stop-sample edge. `irq_o` and `!empty` are high the next cycle.
- **Interrupt clear:** `irq_o` drops the cycle after the pop that empties the FIFO.
- **Pointers:** FIFO pointers are FIFO_AW+1 bits wide; wrap-around is natural. full = MSBs differ and the remaining bits are equal.

## Structure
- **Package `uart_pkg`**, shared with `uart_wb`:
  - RX state encoding;
  - register offsets;
  - STATUS bit positions;
  - oversample constant 16.
- **Sub-module `uart_rx_fifo`:** synchronous FIFO, parameter FIFO_AW. Ports: push, pop, din, dout, empty, full. `dout` shows the head entry without a pop (first-word fall-through).
- FSM, tick generator and register logic stay in the top of `uart_rx_wb`.

## Test plan
All tests use DIVISOR=2.
- **Single byte:** send 8'hA5 at 16·DIVISOR clocks per bit.
  - `irq_o` rises.
  - DATA read returns 16'h01A5.
  - `irq_o` falls the cycle after the ack.
  - A second DATA read returns 16'h0000.
- **Glitch rejection:** pull `rx_i` low for 6 clocks, then high.
  - No push, FSM back in IDLE.
  - A following 8'h3C is received correctly.
- **Overflow:** send 17 bytes 8'h00..8'h10 without reading.
  - STATUS = 16'h0007.
  - 16 DATA reads return 8'h00..8'h0F.
  - Write STATUS 16'h0004, then STATUS reads 16'h0000.
- **Framing error:** send 8'h55 with stop bit 0, hold low for 2 bit times, then high.
  - STATUS bit 3 = 1, FIFO empty.
  - The next byte 8'h81 is received.
  - Write 16'h0008 clears bit 3.
- **Simultaneous push and pop:** FIFO holds 3 bytes; issue a DATA read so its ack lands on the stop-sample cycle.
  - The count stays 3.
  - Reads return the bytes in order.
- **Reset mid-frame:** assert `rst_i` for 1 cycle at data bit 4.
  - All outputs are 0 next cycle.
  - The remaining bits of the interrupted frame produce no push. The line must be idle high for at least one frame after the interrupted byte, before the next byte 8'hC3 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: RX state encoding, register map, STATUS bit layout
// and oversampling constants used by uart_rx_wb and uart_wb.
package uart_pkg;

   localparam int unsigned OVERSAMPLE = 16;

   // Every mid-bit sample lands on the tick whose pre-increment count is 7.
   localparam logic [3:0] SAMPLE_PHASE = 4'(OVERSAMPLE / 2 - 1);

   localparam int unsigned ADR_SEL_BIT = 1;
   localparam logic        REG_DATA    = 1'b0;
   localparam logic        REG_STATUS  = 1'b1;

   localparam int unsigned ST_RX_AVAIL  = 0;
   localparam int unsigned ST_FULL      = 1;
   localparam int unsigned ST_OVERRUN   = 2;
   localparam int unsigned ST_FRAME_ERR = 3;

   typedef enum logic [2:0] {
      RX_IDLE  = 3'd0,
      RX_START = 3'd1,
      RX_DATA  = 3'd2,
      RX_STOP  = 3'd3,
      RX_BRK   = 3'd4
   } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO with first-word fall-through output; pushes to a full FIFO and
// pops of an empty FIFO are ignored.
module uart_rx_fifo #(
   parameter int unsigned FIFO_AW = 4
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       push,
   input  logic       pop,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic       empty,
   output logic       full
);

   logic [7:0]         r_mem [2**FIFO_AW];
   logic [FIFO_AW:0]   r_wr_ptr;
   logic [FIFO_AW:0]   r_rd_ptr;
   logic               w_push;
   logic               w_pop;

   assign w_push = push && !full;
   assign w_pop  = pop && !empty;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_push && !rst_i) r_mem[r_wr_ptr[FIFO_AW-1:0]] <= din;
   end

   assign dout  = r_mem[r_rd_ptr[FIFO_AW-1:0]];
   assign empty = (r_wr_ptr == r_rd_ptr);
   assign full  = (r_wr_ptr[FIFO_AW] != r_rd_ptr[FIFO_AW]) &&
                  (r_wr_ptr[FIFO_AW-1:0] == r_rd_ptr[FIFO_AW-1:0]);

endmodule

// File: rtl/uart_rx_wb.sv
// UART receiver with 16x oversampling, receive FIFO and a 16-bit Wishbone
// slave exposing DATA and STATUS registers plus a FIFO-not-empty interrupt.
module uart_rx_wb
   import uart_pkg::*;
#(
   parameter int unsigned DIVISOR = 18,
   parameter int unsigned FIFO_AW = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [15:0] wb_dat_i,
   output logic [15:0] wb_dat_o,
   input  logic [31:0] wb_adr_i,
   input  logic [1:0]  wb_sel_i,
   input  logic        wb_we_i,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   output logic        wb_ack_o,
   input  logic        rx_i,
   output logic        irq_o
);

   localparam int unsigned DIV_W = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;

   logic             r_sync1;
   logic             r_rxs;
   logic [DIV_W-1:0] r_div;
   logic [3:0]       r_tick_cnt;
   logic [2:0]       r_bit_cnt;
   logic [7:0]       r_shift;
   rx_state_e        r_state;
   rx_state_e        w_state_nx;

   logic             w_tick;
   logic             w_sample;
   logic             w_start;
   logic             w_shift_en;
   logic             w_push;
   logic             w_ferr_set;

   logic             r_ack;
   logic [15:0]      r_dat;
   logic             r_overrun;
   logic             r_frame_err;

   logic             w_acc;
   logic             w_rd;
   logic             w_wr;
   logic             w_sel_status;
   logic             w_pop;
   logic             w_clr_ovr;
   logic             w_clr_fe;
   logic [15:0]      w_status;
   logic [7:0]       w_dout;
   logic             w_empty;
   logic             w_full;
   logic             w_unused;

   assign w_unused = ^{wb_sel_i, wb_adr_i[31:2], wb_adr_i[0],
                       wb_dat_i[15:4], wb_dat_i[1:0]};

   assign w_tick   = (r_div == DIV_W'(DIVISOR - 1));
   assign w_sample = w_tick && (r_tick_cnt == SAMPLE_PHASE);

   always_ff @(posedge clk_i) begin
      if (rst_i) r_state <= RX_IDLE;
      else       r_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx = r_state;
      w_start    = 1'b0;
      w_shift_en = 1'b0;
      w_push     = 1'b0;
      w_ferr_set = 1'b0;
      case (r_state)
         RX_IDLE: begin
            if (!r_rxs) begin
               w_start    = 1'b1;
               w_state_nx = RX_START;
            end
         end
         RX_START: begin
            if (w_sample) w_state_nx = r_rxs ? RX_IDLE : RX_DATA;
         end
         RX_DATA: begin
            if (w_sample) begin
               w_shift_en = 1'b1;
               if (r_bit_cnt == 3'd7) w_state_nx = RX_STOP;
            end
         end
         RX_STOP: begin
            if (w_sample) begin
               if (r_rxs) begin
                  w_push     = 1'b1;
                  w_state_nx = RX_IDLE;
               end else begin
                  w_ferr_set = 1'b1;
                  w_state_nx = RX_BRK;
               end
            end
         end
         RX_BRK: begin
            if (r_rxs) w_state_nx = RX_IDLE;
         end
         default: w_state_nx = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_sync1    <= 1'b1;
         r_rxs      <= 1'b1;
         r_div      <= '0;
         r_tick_cnt <= '0;
         r_bit_cnt  <= '0;
         r_shift    <= '0;
      end else begin
         r_sync1 <= rx_i;
         r_rxs   <= r_sync1;
         // Start-edge realignment wins over the free-running divider.
         if (w_start) begin
            r_div      <= '0;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
         end else if (w_tick) begin
            r_div      <= '0;
            r_tick_cnt <= r_tick_cnt + 1'b1;
         end else begin
            r_div <= r_div + 1'b1;
         end
         if (w_shift_en) begin
            r_shift   <= {r_rxs, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
         end
      end
   end

   uart_rx_fifo #(
      .FIFO_AW (FIFO_AW)
   ) u_fifo (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .push  (w_push),
      .pop   (w_pop),
      .din   (r_shift),
      .dout  (w_dout),
      .empty (w_empty),
      .full  (w_full)
   );

   assign w_acc        = wb_cyc_i && wb_stb_i && !r_ack;
   assign w_rd         = w_acc && !wb_we_i;
   assign w_wr         = w_acc && wb_we_i;
   assign w_sel_status = (wb_adr_i[ADR_SEL_BIT] == REG_STATUS);
   assign w_pop        = w_rd && !w_sel_status && !w_empty;
   assign w_clr_ovr    = w_wr && w_sel_status && wb_dat_i[ST_OVERRUN];
   assign w_clr_fe     = w_wr && w_sel_status && wb_dat_i[ST_FRAME_ERR];

   always_comb begin
      w_status               = '0;
      w_status[ST_RX_AVAIL]  = !w_empty;
      w_status[ST_FULL]      = w_full;
      w_status[ST_OVERRUN]   = r_overrun;
      w_status[ST_FRAME_ERR] = r_frame_err;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_ack       <= 1'b0;
         r_dat       <= '0;
         r_overrun   <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_ack <= w_acc;
         if (w_rd) begin
            if (w_sel_status) r_dat <= w_status;
            else if (w_empty) r_dat <= '0;
            else              r_dat <= {7'b0, 1'b1, w_dout};
         end
         if (w_push && w_full) r_overrun <= 1'b1;
         else if (w_clr_ovr)   r_overrun <= 1'b0;
         if (w_ferr_set)       r_frame_err <= 1'b1;
         else if (w_clr_fe)    r_frame_err <= 1'b0;
      end
   end

   assign wb_ack_o = r_ack;
   assign wb_dat_o = r_dat;
   assign irq_o    = !w_empty;

endmodule

// File: tb/tb_uart_rx_wb.sv
// Scoreboard bench for uart_rx_wb: reads queue their expected word, and a
// negedge monitor compares it against wb_dat_o whenever a read is acknowledged.
module tb_uart_rx_wb;

   localparam int unsigned DIV = 2;
   localparam int unsigned BIT = 16 * DIV;

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic [15:0] wb_dat_i = '0;
   logic [15:0] wb_dat_o;
   logic [31:0] wb_adr_i = '0;
   logic [1:0]  wb_sel_i = 2'b11;
   logic        wb_we_i = 1'b0;
   logic        wb_cyc_i = 1'b0;
   logic        wb_stb_i = 1'b0;
   logic        wb_ack_o;
   logic        rx_i = 1'b1;
   logic        irq_o;

   int          n_tests = 0;
   int          n_fail = 0;
   logic [15:0] q_exp [$];
   string       q_name [$];
   logic [15:0] mon_exp;
   string       mon_name;

   always #5 clk = ~clk;

   uart_rx_wb #(
      .DIVISOR (DIV),
      .FIFO_AW (4)
   ) dut (
      .clk_i    (clk),
      .rst_i    (rst_i),
      .wb_dat_i (wb_dat_i),
      .wb_dat_o (wb_dat_o),
      .wb_adr_i (wb_adr_i),
      .wb_sel_i (wb_sel_i),
      .wb_we_i  (wb_we_i),
      .wb_cyc_i (wb_cyc_i),
      .wb_stb_i (wb_stb_i),
      .wb_ack_o (wb_ack_o),
      .rx_i     (rx_i),
      .irq_o    (irq_o)
   );

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (wb_ack_o && !wb_we_i) begin
         if (q_exp.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_read_ack: got data %h, required no ack", wb_dat_o);
         end else begin
            mon_exp  = q_exp.pop_front();
            mon_name = q_name.pop_front();
            chk(mon_name, wb_dat_o, mon_exp);
         end
      end
   end

   task automatic wb_cycle(input logic we, input logic status, input logic [15:0] wdata,
                           input logic [15:0] exp, input string name);
      logic got;
      @(posedge clk); #1;
      wb_cyc_i = 1'b1;
      wb_stb_i = 1'b1;
      wb_we_i  = we;
      wb_adr_i = status ? 32'h0000_0002 : 32'h0000_0000;
      wb_dat_i = wdata;
      if (!we) begin
         q_exp.push_back(exp);
         q_name.push_back(name);
      end
      got = 1'b0;
      for (int i = 0; i < 8 && !got; i++) begin
         @(posedge clk); #1;
         if (wb_ack_o) got = 1'b1;
      end
      if (!got) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s_ack_timeout: got no ack, required ack within 8 cycles", name);
         if (!we) begin
            void'(q_exp.pop_back());
            void'(q_name.pop_back());
         end
      end
      @(negedge clk); #1;
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      wb_we_i  = 1'b0;
   endtask

   task automatic wb_rd(input logic status, input logic [15:0] exp, input string name);
      wb_cycle(1'b0, status, 16'h0000, exp, name);
   endtask

   task automatic wb_wr(input logic status, input logic [15:0] wdata);
      wb_cycle(1'b1, status, wdata, 16'h0000, "write");
   endtask

   task automatic send_byte(input logic [7:0] d, input logic stopb, input int extra_low);
      @(posedge clk); #1 rx_i = 1'b0;
      repeat (BIT) @(posedge clk);
      for (int i = 0; i < 8; i++) begin
         #1 rx_i = d[i];
         repeat (BIT) @(posedge clk);
      end
      #1 rx_i = stopb;
      repeat (BIT) @(posedge clk);
      if (extra_low > 0) repeat (extra_low) @(posedge clk);
      #1 rx_i = 1'b1;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: got no completion, required finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_i = 1'b1;
      wait_cycles(3);
      rst_i = 1'b0;
      chk("reset_ack", {15'b0, wb_ack_o}, 16'h0000);
      chk("reset_dat", wb_dat_o, 16'h0000);
      chk("reset_irq", {15'b0, irq_o}, 16'h0000);
      wb_rd(1'b1, 16'h0000, "reset_status");

      // single byte
      send_byte(8'hA5, 1'b1, 0);
      wait_cycles(2);
      chk("t1_irq_high", {15'b0, irq_o}, 16'h0001);
      wb_rd(1'b0, 16'h01A5, "t1_data");
      wait_cycles(1);
      chk("t1_irq_low", {15'b0, irq_o}, 16'h0000);
      wb_rd(1'b0, 16'h0000, "t1_empty_read");

      // glitch rejection
      @(posedge clk); #1 rx_i = 1'b0;
      repeat (6) @(posedge clk);
      #1 rx_i = 1'b1;
      wait_cycles(40);
      chk("t2_no_push_irq", {15'b0, irq_o}, 16'h0000);
      wb_rd(1'b1, 16'h0000, "t2_status");
      send_byte(8'h3C, 1'b1, 0);
      wait_cycles(2);
      wb_rd(1'b0, 16'h013C, "t2_data");

      // overflow
      for (int b = 0; b < 17; b++) send_byte(8'(b), 1'b1, 0);
      wait_cycles(2);
      wb_rd(1'b1, 16'h0007, "t3_status_full");
      for (int b = 0; b < 16; b++) wb_rd(1'b0, 16'h0100 | 16'(b), $sformatf("t3_data%0d", b));
      wb_wr(1'b1, 16'h0004);
      wb_rd(1'b1, 16'h0000, "t3_status_cleared");

      // framing error
      send_byte(8'h55, 1'b0, 2 * BIT);
      wait_cycles(10);
      wb_rd(1'b1, 16'h0008, "t4_status_ferr");
      send_byte(8'h81, 1'b1, 0);
      wait_cycles(2);
      wb_rd(1'b0, 16'h0181, "t4_data");
      wb_rd(1'b1, 16'h0008, "t4_status_sticky");
      wb_wr(1'b1, 16'h0008);
      wb_rd(1'b1, 16'h0000, "t4_status_cleared");

      // simultaneous push and pop: pop edge coincides with the stop-sample edge
      send_byte(8'h11, 1'b1, 0);
      send_byte(8'h22, 1'b1, 0);
      send_byte(8'h33, 1'b1, 0);
      fork
         send_byte(8'h44, 1'b1, 0);
         begin
            repeat (306) @(posedge clk);
            wb_rd(1'b0, 16'h0111, "t5_pop_at_push");
         end
      join
      wait_cycles(2);
      wb_rd(1'b0, 16'h0122, "t5_data1");
      wb_rd(1'b0, 16'h0133, "t5_data2");
      wb_rd(1'b0, 16'h0144, "t5_data3");
      wb_rd(1'b0, 16'h0000, "t5_now_empty");

      // reset mid-frame, during data bit 4
      send_byte(8'h77, 1'b1, 0);
      wait_cycles(2);
      chk("t6_irq_before", {15'b0, irq_o}, 16'h0001);
      wb_rd(1'b1, 16'h0001, "t6_status_before");
      fork
         send_byte(8'hF0, 1'b1, 0);
         begin
            repeat (175) @(posedge clk);
            #1 rst_i = 1'b1;
            @(posedge clk);
            #1 rst_i = 1'b0;
            chk("t6_rst_ack", {15'b0, wb_ack_o}, 16'h0000);
            chk("t6_rst_dat", wb_dat_o, 16'h0000);
            chk("t6_rst_irq", {15'b0, irq_o}, 16'h0000);
         end
      join
      wait_cycles(BIT * 10 + 10);
      chk("t6_no_push_irq", {15'b0, irq_o}, 16'h0000);
      wb_rd(1'b1, 16'h0000, "t6_status_after");
      send_byte(8'hC3, 1'b1, 0);
      wait_cycles(2);
      wb_rd(1'b0, 16'h01C3, "t6_data");

      wait_cycles(4);
      chk("scoreboard_drained", 16'(q_exp.size()), 16'h0000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
